// File: rtl/rope_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rope_pkg : shared rope status / shock FSM types and the default rope count
// Rev 1.0
// ---------------------------------------------------------------------------
package rope_pkg;

  // Shared with the upstream rope electro-status timer.
  localparam int ROPES_DEFAULT = 6;

  typedef enum logic [1:0] {
    ESTAT_IDLE = 2'b00,
    ESTAT_WARN = 2'b01,
    ESTAT_ELEC = 2'b10
  } electro_status_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CONTACT  = 2'b01,
    SHOCKED  = 2'b10,
    COOLDOWN = 2'b11
  } shock_state_t;

  // Raw 2'b11 never matches any named status, so it behaves as idle.
  function automatic logic is_status(input logic [1:0] raw, input electro_status_t s);
    return raw == s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rope_blink_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rope_blink_gen : frame-tick blink counter, phase toggles every BLINK_FRAMES
// Rev 1.0
// ---------------------------------------------------------------------------
module rope_blink_gen #(
  parameter int BLINK_FRAMES = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic frameTick,
  output logic blinkPhase
);

  localparam logic [7:0] LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] blinkCnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b1;
    end else if (frameTick) begin
      if (blinkCnt >= LAST) begin
        blinkCnt   <= '0;
        blinkPhase <= ~blinkPhase;
      end else begin
        blinkCnt <= blinkCnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rope_shock_manager.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rope_shock_manager : rope contact dwell -> shock/stun/cooldown, warning blink
// Optional lives/game-over logic with `define ROPE_SHOCK_LIVES_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module rope_shock_manager
  import rope_pkg::*;
#(
  parameter int ROPES        = ROPES_DEFAULT,
  parameter int DWELL_FRAMES = 3,
  parameter int STUN_FRAMES  = 45,
  parameter int COOL_FRAMES  = 60,
  parameter int BLINK_FRAMES = 8
`ifdef ROPE_SHOCK_LIVES_EN
  ,
  parameter int LIVES        = 3
`endif
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic [ROPES-1:0][1:0]      electroStatus,
  input  logic [ROPES-1:0]           ropeHit,
  output logic                       shockPulse,
  output logic                       playerStunned,
  output logic                       playerInvuln,
  output logic [ROPES-1:0]           ropeBlink,
`ifdef ROPE_SHOCK_LIVES_EN
  output logic [1:0]                 livesLeft,
  output logic                       gameOver,
`endif
  output logic [$clog2(ROPES)-1:0]   shockRope
);

  localparam int         IDX_W     = $clog2(ROPES);
  localparam logic [3:0] DWELL_M1  = 4'(DWELL_FRAMES - 1);
  localparam logic       DWELL_ONE = (DWELL_FRAMES == 1);
  localparam logic       COOL_NONE = (COOL_FRAMES == 0);
  localparam logic [7:0] STUN_INIT = 8'(STUN_FRAMES);
  localparam logic [7:0] COOL_INIT = 8'(COOL_FRAMES);

  logic [ROPES-1:0] touchAcc;
  logic [ROPES-1:0] elecMask;
  logic [IDX_W-1:0] hotIdxNext;
  logic [IDX_W-1:0] hotIdx;
  logic             hotFrame;
  logic             evalTick;
  logic             fireNow;
  logic             frozen;
  logic             blinkPhase;

  shock_state_t     state;
  logic [3:0]       dwellCnt;
  logic [7:0]       stunCnt;
  logic [7:0]       coolCnt;

  // Lowest electrified rope the player touched during the closing frame.
  always_comb begin
    elecMask   = '0;
    hotIdxNext = '0;
    for (int i = ROPES - 1; i >= 0; i--) begin
      elecMask[i] = is_status(electroStatus[i], ESTAT_ELEC);
      if (touchAcc[i] && elecMask[i]) hotIdxNext = IDX_W'(i);
    end
  end

  // A hit coinciding with the frame tick starts the new accumulator.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      touchAcc <= '0;
      hotFrame <= 1'b0;
      hotIdx   <= '0;
      evalTick <= 1'b0;
    end else begin
      evalTick <= startOfFrame;
      if (startOfFrame) begin
        touchAcc <= ropeHit;
        hotFrame <= |(touchAcc & elecMask);
        hotIdx   <= hotIdxNext;
      end else begin
        touchAcc <= touchAcc | ropeHit;
      end
    end
  end

  always_comb begin
    fireNow = 1'b0;
    if (evalTick && hotFrame && !frozen) begin
      case (state)
        IDLE:    fireNow = DWELL_ONE;
        CONTACT: fireNow = (dwellCnt >= DWELL_M1);
        default: fireNow = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      dwellCnt      <= '0;
      stunCnt       <= '0;
      coolCnt       <= '0;
      shockPulse    <= 1'b0;
      playerStunned <= 1'b0;
      playerInvuln  <= 1'b0;
      shockRope     <= '0;
    end else begin
      shockPulse <= 1'b0;
      if (fireNow) begin
        state         <= SHOCKED;
        dwellCnt      <= '0;
        stunCnt       <= STUN_INIT;
        shockPulse    <= 1'b1;
        shockRope     <= hotIdx;
        playerStunned <= 1'b1;
        playerInvuln  <= 1'b1;
      end else if (evalTick && !frozen) begin
        case (state)
          IDLE: begin
            if (hotFrame) begin
              state    <= CONTACT;
              dwellCnt <= 4'd1;
            end
          end
          CONTACT: begin
            if (hotFrame) begin
              if (dwellCnt != 4'hF) dwellCnt <= dwellCnt + 4'd1;
            end else begin
              state    <= IDLE;
              dwellCnt <= '0;
            end
          end
          SHOCKED: begin
            if (stunCnt <= 8'd1) begin
              stunCnt       <= '0;
              playerStunned <= 1'b0;
              if (COOL_NONE) begin
                state        <= IDLE;
                playerInvuln <= 1'b0;
              end else begin
                state   <= COOLDOWN;
                coolCnt <= COOL_INIT;
              end
            end else begin
              stunCnt <= stunCnt - 8'd1;
            end
          end
          COOLDOWN: begin
            if (coolCnt <= 8'd1) begin
              coolCnt      <= '0;
              state        <= IDLE;
              playerInvuln <= 1'b0;
            end else begin
              coolCnt <= coolCnt - 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ROPE_SHOCK_LIVES_EN
  // The last life's shock still pulses; afterwards the FSM is held stunned.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      livesLeft <= 2'(LIVES);
      gameOver  <= 1'b0;
    end else if (fireNow) begin
      if (livesLeft != 2'd0) livesLeft <= livesLeft - 2'd1;
      if (livesLeft <= 2'd1) gameOver <= 1'b1;
    end
  end
  assign frozen = gameOver;
`else
  assign frozen = 1'b0;
`endif

  rope_blink_gen #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk        (clk),
    .resetN     (resetN),
    .frameTick  (startOfFrame),
    .blinkPhase (blinkPhase)
  );

  always_comb begin
    ropeBlink = '1;
    for (int i = 0; i < ROPES; i++) begin
      if (is_status(electroStatus[i], ESTAT_WARN)) ropeBlink[i] = blinkPhase;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rope_shock_manager.sv
`default_nettype none
// tb_rope_shock_manager: directed table, hand sequences and random frames
// checked against a frame-level timeline model of the shock manager.
module tb_rope_shock_manager;

  localparam int ROPES = 6;
  localparam int DWELL = 3;
  localparam int STUN  = 45;
  localparam int COOL  = 60;
  localparam int BLINK = 8;
  localparam int FLEN  = 4;
  localparam int LIVES = 3;

  logic                  clk = 1'b0;
  logic                  resetN = 1'b1;
  logic                  startOfFrame = 1'b0;
  logic [ROPES-1:0][1:0] electroStatus = '0;
  logic [ROPES-1:0]      ropeHit = '0;
  logic                  shockPulse;
  logic                  playerStunned;
  logic                  playerInvuln;
  logic [ROPES-1:0]      ropeBlink;
  logic [2:0]            shockRope;
`ifdef ROPE_SHOCK_LIVES_EN
  logic [1:0]            livesLeft;
  logic                  gameOver;
`endif

  rope_shock_manager #(
    .ROPES(ROPES), .DWELL_FRAMES(DWELL), .STUN_FRAMES(STUN),
    .COOL_FRAMES(COOL), .BLINK_FRAMES(BLINK)
`ifdef ROPE_SHOCK_LIVES_EN
    , .LIVES(LIVES)
`endif
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .electroStatus (electroStatus),
    .ropeHit       (ropeHit),
    .shockPulse    (shockPulse),
    .playerStunned (playerStunned),
    .playerInvuln  (playerInvuln),
    .ropeBlink     (ropeBlink),
`ifdef ROPE_SHOCK_LIVES_EN
    .livesLeft     (livesLeft),
    .gameOver      (gameOver),
`endif
    .shockRope     (shockRope)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: frames are numbered by evaluation; a shock at evaluation
  // e stuns through e+STUN-1, protects through e+STUN+COOL-1 and ignores
  // contact up to and including evaluation e+STUN+COOL.
  int                    evalIdx, lastShock, run, sofCount, expRope, pendIdx, livesM;
  bit                    pendEval, pendHot, expPulse, expStun, expInv, gameOverM;
  logic [ROPES-1:0]      frameHit;
  logic [ROPES-1:0][1:0] curStat = '0;
  int                    pulsesSeen;

  task automatic model_reset();
    evalIdx = 0; lastShock = -1; run = 0; sofCount = 0; expRope = 0; pendIdx = 0;
    pendEval = 0; pendHot = 0; expPulse = 0; expStun = 0; expInv = 0;
    gameOverM = 0; livesM = LIVES; frameHit = '0;
  endtask

  function automatic logic [ROPES-1:0][1:0] mk_stat(input int rope, input logic [1:0] v);
    logic [ROPES-1:0][1:0] s;
    s = '0;
    s[rope] = v;
    return s;
  endfunction

  function automatic logic [ROPES-1:0] blink_exp(input logic [ROPES-1:0][1:0] st);
    logic [ROPES-1:0] b;
    bit ph;
    ph = ((sofCount / BLINK) % 2) == 0;
    for (int i = 0; i < ROPES; i++) b[i] = (st[i] == 2'b01) ? ph : 1'b1;
    return b;
  endfunction

  task automatic model_eval();
    int d;
    bit fire;
    fire = 0;
    d = evalIdx - lastShock;
    if (gameOverM) run = 0;
    else if (lastShock >= 0 && d >= 1 && d <= STUN + COOL) run = 0;
    else if (pendHot) begin
      run++;
      if (run >= DWELL) fire = 1;
    end else run = 0;
    if (fire) begin
      lastShock = evalIdx;
      expRope = pendIdx;
      run = 0;
`ifdef ROPE_SHOCK_LIVES_EN
      if (livesM > 0) livesM--;
      if (livesM == 0) gameOverM = 1;
`endif
    end
    expPulse = fire;
    d = evalIdx - lastShock;
    if (gameOverM) begin
      expStun = 1; expInv = 1;
    end else begin
      expStun = (lastShock >= 0) && (d < STUN);
      expInv  = (lastShock >= 0) && (d < STUN + COOL);
    end
    evalIdx++;
  endtask

  task automatic do_cycle(input bit sof, input logic [ROPES-1:0] hit,
                          input logic [ROPES-1:0][1:0] st);
    startOfFrame = sof; ropeHit = hit; electroStatus = st;
    @(posedge clk); #1;
    expPulse = 0;
    if (pendEval) begin
      pendEval = 0;
      model_eval();
    end
    if (sof) begin
      pendHot = 0; pendIdx = 0;
      for (int i = ROPES - 1; i >= 0; i--)
        if (frameHit[i] && st[i] == 2'b10) begin pendHot = 1; pendIdx = i; end
      pendEval = 1;
      frameHit = hit;
      sofCount++;
    end else begin
      frameHit = frameHit | hit;
    end
    if (shockPulse === 1'b1) pulsesSeen++;
    check("shockPulse", shockPulse, expPulse);
    check("playerStunned", playerStunned, expStun);
    check("playerInvuln", playerInvuln, expInv);
    check("shockRope", shockRope, expRope);
    check("ropeBlink", ropeBlink, blink_exp(st));
`ifdef ROPE_SHOCK_LIVES_EN
    check("livesLeft", livesLeft, livesM);
    check("gameOver", gameOver, gameOverM);
`endif
  endtask

  task automatic run_frame(input logic [ROPES-1:0] hit, input logic [ROPES-1:0][1:0] st,
                           input bit onSof);
    do_cycle(1'b1, onSof ? hit : '0, curStat);
    do_cycle(1'b0, onSof ? '0 : hit, st);
    for (int c = 2; c < FLEN; c++) do_cycle(1'b0, '0, st);
    curStat = st;
  endtask

  task automatic apply_reset(input int cycles);
    resetN = 1'b0; startOfFrame = 1'b0; ropeHit = '0;
    #1;
    check("rst_async_shockPulse", shockPulse, 0);
    check("rst_async_stunned", playerStunned, 0);
    check("rst_async_invuln", playerInvuln, 0);
    check("rst_async_shockRope", shockRope, 0);
    check("rst_async_ropeBlink", ropeBlink, {ROPES{1'b1}});
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_hold_shockPulse", shockPulse, 0);
    check("rst_hold_invuln", playerInvuln, 0);
`ifdef ROPE_SHOCK_LIVES_EN
    check("rst_livesLeft", livesLeft, LIVES);
    check("rst_gameOver", gameOver, 0);
`endif
    resetN = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit               doReset;
    logic [ROPES-1:0] hit;
    int               elecRope;
    bit               onSof;
    bit               expShock;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, stunFrames, invFrames, toggles;
    logic lastB;
    logic [ROPES-1:0][1:0] st;

    // Broken run (frames 0,1 hot, 2 miss) then frames 3,4,5 hot -> shock in 6.
    tbl[0]  = '{1, 6'b001000, 3, 0, 0};
    tbl[1]  = '{0, 6'b001000, 3, 0, 0};
    tbl[2]  = '{0, 6'b000000, 3, 0, 0};
    tbl[3]  = '{0, 6'b001000, 3, 0, 0};
    tbl[4]  = '{0, 6'b001000, 3, 0, 0};
    tbl[5]  = '{0, 6'b001000, 3, 0, 0};
    tbl[6]  = '{0, 6'b000000, 3, 0, 1};
    // Hit on the tick cycle belongs to the frame that tick opens.
    tbl[7]  = '{1, 6'b000001, 0, 0, 0};
    tbl[8]  = '{0, 6'b000001, 0, 0, 0};
    tbl[9]  = '{0, 6'b000001, 0, 1, 0};
    tbl[10] = '{0, 6'b000000, 0, 0, 1};
    tbl[11] = '{1, 6'b000010, 1, 1, 0};
    tbl[12] = '{0, 6'b000010, 1, 1, 0};
    tbl[13] = '{0, 6'b000010, 1, 1, 0};
    tbl[14] = '{0, 6'b000000, 1, 0, 1};

    model_reset();
    #2;
    apply_reset(3);

    foreach (tbl[k]) begin
      if (tbl[k].doReset) apply_reset(2);
      p0 = pulsesSeen;
      run_frame(tbl[k].hit, mk_stat(tbl[k].elecRope, 2'b10), tbl[k].onSof);
      check($sformatf("tbl%0d_shock", k), pulsesSeen - p0, tbl[k].expShock ? 1 : 0);
    end

    // Full shock on rope 2: 45 stunned frames then 60 invulnerable-only frames.
    apply_reset(2);
    st = mk_stat(2, 2'b10);
    pulsesSeen = 0; stunFrames = 0; invFrames = 0;
    for (int f = 0; f < 3; f++) run_frame(6'b000100, st, 0);
    for (int f = 0; f < 110; f++) begin
      run_frame('0, st, 0);
      if (playerStunned) stunFrames++;
      else if (playerInvuln) invFrames++;
    end
    check("seq1_pulses", pulsesSeen, 1);
    check("seq1_rope", shockRope, 2);
    check("seq1_stun_frames", stunFrames, STUN);
    check("seq1_cool_frames", invFrames, COOL);

    // Warning rope: contact never shocks, rope 1 blinks every BLINK frames.
    apply_reset(2);
    st = mk_stat(1, 2'b01);
    pulsesSeen = 0; toggles = 0; lastB = 1'b1;
    for (int f = 0; f < 20; f++) begin
      run_frame(f < 10 ? 6'b000010 : 6'b000000, st, 0);
      if (ropeBlink[1] !== lastB) toggles++;
      lastB = ropeBlink[1];
      check("warn_others_steady", ropeBlink | 6'b000010, 6'b111111);
    end
    check("warn_no_shock", pulsesSeen, 0);
    check("warn_toggles", toggles, 2);

    // Reset in the middle of a stun aborts it for good.
    apply_reset(2);
    st = mk_stat(5, 2'b10);
    for (int f = 0; f < 3; f++) run_frame(6'b100000, st, 0);
    for (int f = 0; f < 10; f++) run_frame('0, st, 0);
    check("midrst_stunned_before", playerStunned, 1);
    apply_reset(2);
    pulsesSeen = 0;
    for (int f = 0; f < 10; f++) run_frame('0, st, 0);
    check("midrst_no_pulse", pulsesSeen, 0);

    // Randomised frames with sticky rope statuses.
    apply_reset(2);
    st = '0;
    for (int f = 0; f < 600; f++) begin
      for (int i = 0; i < ROPES; i++)
        if ($urandom_range(0, 5) == 0) st[i] = 2'($urandom_range(0, 3));
      run_frame(ROPES'($urandom & $urandom), st, $urandom_range(0, 3) == 0);
    end

`ifdef ROPE_SHOCK_LIVES_EN
    apply_reset(2);
    st = mk_stat(4, 2'b10);
    for (int s = 0; s < 3; s++) begin
      for (int f = 0; f < 3; f++) run_frame(6'b010000, st, 0);
      for (int f = 0; f < 106; f++) run_frame('0, st, 0);
      check($sformatf("lives_after_%0d", s + 1), livesLeft, 2 - s);
    end
    check("lives_gameover", gameOver, 1);
    pulsesSeen = 0;
    for (int f = 0; f < 6; f++) run_frame(6'b010000, st, 0);
    check("lives_no_more_shock", pulsesSeen, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rope_shock_manager.md
Name: rope_shock_manager

Overview:
- Sits directly downstream of the rope electro-status timer; consumes its per-rope 2-bit status vector.
- Combines that vector with per-rope player collision pulses from the drawing/collision stage.
- Produces a shock event, a stun/invulnerability state for the player controller, and per-rope blink enables for the rope drawer.
- All game-time behaviour advances on startOfFrame (30 Hz frame tick).

Parameters:
- ROPES, 6, number of ropes; width of all per-rope vectors.
- DWELL_FRAMES, 3, consecutive electrified-contact frames before a shock fires (1..15).
- STUN_FRAMES, 45, frames the player is stunned after a shock (1..255).
- COOL_FRAMES, 60, invulnerable frames after stun ends (0..255).
- BLINK_FRAMES, 8, half-period in frames of warning-rope blink (1..255).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle frame tick
- electroStatus  in  [ROPES-1:0][1:0]  per rope: 00 idle, 01 warning, 10 electrified, 11 treated as idle
- ropeHit  in  [ROPES]  per-rope player/rope pixel collision, any cycle within a frame
- shockPulse  out  1  one-cycle pulse when a shock is applied
- playerStunned  out  1  high during SHOCKED
- playerInvuln  out  1  high during SHOCKED and COOLDOWN
- ropeBlink  out  [ROPES]  per-rope draw enable; 0 means draw rope dark this frame
- shockRope  out  $clog2(ROPES)  index of rope that caused the last shock

Behaviour:
- Reset, asynchronous and active-low: state IDLE; all counters 0; shockPulse=0; playerStunned=0; playerInvuln=0; ropeBlink all 1; shockRope=0; contact accumulator cleared.
- Reset mid-operation aborts any dwell, stun or cooldown immediately.
- Contact accumulation: touchAcc |= ropeHit every cycle.
  - On startOfFrame, touchAcc is sampled into touchFrame and cleared.
  - A ropeHit in the same cycle as startOfFrame goes into the next frame's accumulator, not the sampled one.
- hot = OR over i of (touchFrame[i] && electroStatus[i]==2'b10), evaluated using electroStatus at the sampling cycle.
  - hotIdx = lowest such i.
- FSM transitions occur only on startOfFrame, one cycle after sampling, using the sampled touchFrame.
- IDLE: if hot, dwellCnt=1 and go to CONTACT; if DWELL_FRAMES==1, fire immediately (see fire).
- CONTACT:
  - hot: dwellCnt++.
  - Reaching DWELL_FRAMES fires: shockPulse=1 for exactly one cycle, shockRope=hotIdx, stunCnt=STUN_FRAMES, go to SHOCKED.
  - Not hot: dwellCnt=0, go to IDLE (contact must be consecutive).
  - A rope leaving status 10 counts as not hot.
- SHOCKED: stunCnt-- per frame; at 0 go to COOLDOWN with coolCnt=COOL_FRAMES, or go directly to IDLE if COOL_FRAMES==0. Contacts are ignored.
- COOLDOWN: coolCnt-- per frame; at 0 go to IDLE. Contacts are ignored; dwell does not pre-accumulate.
- Counters saturate and never wrap; decrement is guarded at 0.
- Blink:
  - Free-running blinkCnt counts frames 0..BLINK_FRAMES-1; on wrap, blinkPhase toggles.
  - ropeBlink[i] = blinkPhase when electroStatus[i]==01, else 1.
  - Combinational from the registered blinkPhase, so a status change takes effect the same cycle.
- Outputs are registered except ropeBlink.
- Latency: electrified contact within frame N yields shockPulse 1 cycle after the startOfFrame ending frame N+DWELL_FRAMES-1.

Optional Feature:
- Macro: ROPE_SHOCK_LIVES_EN.
- Defined:
  - Adds parameter LIVES (default 3) and outputs livesLeft [1:0] and gameOver (1).
  - Each shockPulse decrements livesLeft, saturating at 0.
  - The shock that takes livesLeft to 0 asserts gameOver, which stays high until reset; the FSM then freezes in SHOCKED with shockPulse suppressed.
  - Reset: livesLeft=LIVES, gameOver=0.
- Not defined: no lives logic, ports absent, unlimited shocks.

Decomposition:
- Shared package rope_pkg:
  - electro_status_t enum: ESTAT_IDLE=2'b00, ESTAT_WARN=2'b01, ESTAT_ELEC=2'b10.
  - shock_state_t enum: IDLE, CONTACT, SHOCKED, COOLDOWN.
  - Default ROPES constant, shared with the upstream rope timer.
- One natural sub-module: rope_blink_gen (frame-tick blink counter/phase generator), reusable by other warning graphics.

Test Plan:
- Rope 2 status 10, ropeHit[2] pulsed once in each of 3 consecutive frames -> shockPulse one cycle after the 3rd sampling tick; shockRope=2; playerStunned high for 45 frames; then playerInvuln alone for 60 frames; then IDLE.
- Contact frames 1,2, miss frame 3, contact 4,5 -> no shock; shock only after frames 4,5,6 all hot.
- Rope 1 status 01 with contact for 10 frames -> no shock; ropeBlink[1] toggles every 8 frames; other ropes steady 1.
- ropeHit asserted exactly on the startOfFrame cycle -> counted in the following frame, verified by dwell timing shifting by one frame.
- Shock in progress, then resetN low for 2 cycles mid-SHOCKED -> all outputs return to reset values immediately; shockPulse never reasserts.
- ROPE_SHOCK_LIVES_EN defined, LIVES=3, three completed shock sequences -> livesLeft 2,1,0; gameOver high after the third; a further contact produces no shockPulse.
